// File: rtl/fifo_tick_reader_pkg.sv
// Shared definitions for the FIFO read-side controller: default widths,
// the controller state encoding and the hold-counter width helper.
package fifo_tick_reader_pkg;

    localparam int DEFAULT_DATA_W     = 8;
    localparam int DEFAULT_HOLD_TICKS = 4;
    localparam int DEFAULT_CNT_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_CAPT = 3'd2,
        ST_PRES = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    // Counter width able to hold 0..ticks; never narrower than one bit.
    function automatic int hold_cnt_width(input int ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/fifo_tick_reader_tick_hold_cnt.sv
// Display-hold tick counter: counts pacing ticks while enabled, saturates at
// HOLD_TICKS and reports done once that many ticks have been seen.
module fifo_tick_reader_tick_hold_cnt
    import fifo_tick_reader_pkg::*;
#(
    parameter int HOLD_TICKS = DEFAULT_HOLD_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic done
);

    localparam int            CW    = hold_cnt_width(HOLD_TICKS);
    localparam logic [CW-1:0] LIMIT = CW'(HOLD_TICKS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance on an enabled tick until the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && tick && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LIMIT);

endmodule

// File: rtl/fifo_tick_reader.sv
// Read-side FIFO controller: pops one word per pacing tick, presents it on a
// valid/ready handshake, then holds it for display for HOLD_TICKS ticks.
module fifo_tick_reader
    import fifo_tick_reader_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int HOLD_TICKS = DEFAULT_HOLD_TICKS,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic              busy
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic [CNT_W-1:0]  rd_count_q;
    logic [CNT_W-1:0]  rd_count_d;
    logic              hold_clear;
    logic              hold_done;

    fifo_tick_reader_tick_hold_cnt #(
        .HOLD_TICKS (HOLD_TICKS)
    ) u_hold_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (hold_clear),
        .enable (state_q == ST_HOLD),
        .tick   (tick),
        .done   (hold_done)
    );

    // Next-state, capture and handshake bookkeeping; ticks only matter in IDLE and HOLD.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        rd_count_d = rd_count_q;
        hold_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && tick && !fifo_empty) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                out_data_d = fifo_dout;
                state_d    = ST_PRES;
            end
            ST_PRES: begin
                if (out_ready) begin
                    rd_count_d = rd_count_q + CNT_W'(1);
                    hold_clear = 1'b1;
                    state_d    = (HOLD_TICKS == 0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, displayed word and handoff counter; reset discards any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign fifo_rd_en = (state_q == ST_POP);
    assign out_valid  = (state_q == ST_PRES);
    assign busy       = (state_q != ST_IDLE);
    assign out_data   = out_data_q;
    assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_fifo_tick_reader.sv
// Directed bench for fifo_tick_reader with a behavioural FIFO read port.
module tb_fifo_tick_reader;

    localparam int DATA_W     = 8;
    localparam int HOLD_TICKS = 4;
    localparam int CNT_W      = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick;
    logic              start;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_dout  = '0;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  rd_count;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;
    int rdEnCount   = 0;
    int tickCnt     = 0;

    logic [DATA_W-1:0] fifoQ[$];
    logic [DATA_W-1:0] got[$];
    logic [CNT_W-1:0]  cntSeq[$];
    int                popTicks[$];

    fifo_tick_reader #(
        .DATA_W     (DATA_W),
        .HOLD_TICKS (HOLD_TICKS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start      (start),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd_count   (rd_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // FIFO read port model: data appears the cycle after a pop, empty flag tracks the queue.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rdEnCount = rdEnCount + 1;
            if (fifoQ.size() > 0) begin
                fifo_dout <= fifoQ.pop_front();
            end
        end
        fifo_empty <= (fifoQ.size() == 0);
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic t, input logic s, input logic r);
        tick      = t;
        start     = s;
        out_ready = r;
    endtask

    task automatic pulseTick();
        tick = 1'b1;
        cycle(1);
        tick = 1'b0;
        cycle(1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Free-running paced drain: tick every other cycle, logging pops and handshakes.
    task automatic runPaced(input int maxCycles, input int stopAfter);
        for (int c = 0; c < maxCycles; c++) begin
            tick = (c % 2 == 0);
            if (tick) tickCnt++;
            cycle(1);
            if (fifo_rd_en) popTicks.push_back(tickCnt);
            if (out_valid && out_ready) got.push_back(out_data);
            if (stopAfter > 0 && got.size() == stopAfter && busy && !out_valid) start = 1'b0;
        end
        tick = 1'b0;
    endtask

    initial begin
        int gap;
        logic [CNT_W-1:0] lastCnt;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        cycle(2);
        checkOutput("rst_rd_en", fifo_rd_en, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_count", rd_count, 0);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
        cycle(1);

        $display("[TB] single word");
        fifoQ.push_back(8'hA5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        cycle(1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        cycle(1);
        tick = 1'b0;
        checkOutput("sw_pop_rd_en", fifo_rd_en, 1);
        checkOutput("sw_pop_valid", out_valid, 0);
        checkOutput("sw_pop_busy", busy, 1);
        cycle(1);
        checkOutput("sw_capt_rd_en", fifo_rd_en, 0);
        checkOutput("sw_capt_valid", out_valid, 0);
        cycle(1);
        checkOutput("sw_pres_valid", out_valid, 1);
        checkOutput("sw_pres_data", out_data, 8'hA5);
        checkOutput("sw_pres_count", rd_count, 0);
        cycle(1);
        checkOutput("sw_hold_valid", out_valid, 0);
        checkOutput("sw_hold_count", rd_count, 1);
        checkOutput("sw_hold_data", out_data, 8'hA5);
        checkOutput("sw_pops", rdEnCount, 1);
        repeat (3) pulseTick();
        tick = 1'b1;
        cycle(1);
        tick = 1'b0;
        checkOutput("sw_hold_4th_busy", busy, 1);
        cycle(1);
        checkOutput("sw_idle_busy", busy, 0);
        checkOutput("sw_idle_data", out_data, 8'hA5);

        $display("[TB] backpressure");
        fifoQ.push_back(8'h3C);
        applyStimulus(1'b0, 1'b1, 1'b0);
        cycle(1);
        tick = 1'b1;
        cycle(1);
        tick = 1'b0;
        cycle(2);
        checkOutput("bp_valid", out_valid, 1);
        checkOutput("bp_data", out_data, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            tick = (i == 2);
            cycle(1);
            checkOutput($sformatf("bp_stall%0d_valid", i), out_valid, 1);
            checkOutput($sformatf("bp_stall%0d_data", i), out_data, 8'h3C);
            checkOutput($sformatf("bp_stall%0d_count", i), rd_count, 1);
        end
        tick = 1'b0;
        checkOutput("bp_pops", rdEnCount, 2);
        out_ready = 1'b1;
        cycle(1);
        checkOutput("bp_accept_valid", out_valid, 0);
        checkOutput("bp_accept_count", rd_count, 2);
        repeat (4) pulseTick();
        checkOutput("bp_idle_busy", busy, 0);

        $display("[TB] empty fifo");
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (20) pulseTick();
        checkOutput("empty_pops", rdEnCount, 2);
        checkOutput("empty_busy", busy, 0);
        checkOutput("empty_count", rd_count, 2);

        $display("[TB] drain three words");
        fifoQ.push_back(8'h01);
        fifoQ.push_back(8'h02);
        fifoQ.push_back(8'h03);
        cycle(1);
        got.delete();
        popTicks.delete();
        runPaced(120, 0);
        checkOutput("drain_pops", popTicks.size(), 3);
        checkOutput("drain_words", got.size(), 3);
        checkOutput("drain_w0", (got.size() > 0) ? got[0] : 8'hxx, 8'h01);
        checkOutput("drain_w1", (got.size() > 1) ? got[1] : 8'hxx, 8'h02);
        checkOutput("drain_w2", (got.size() > 2) ? got[2] : 8'hxx, 8'h03);
        for (int i = 1; i < 3; i++) begin
            gap = (popTicks.size() > i) ? popTicks[i] - popTicks[i-1] : 0;
            checkOutput($sformatf("drain_gap%0d", i), 32'(gap >= 4), 1);
        end
        checkOutput("drain_count", rd_count, 1);
        checkOutput("drain_busy", busy, 0);

        $display("[TB] stop during hold");
        fifoQ.push_back(8'h04);
        fifoQ.push_back(8'h05);
        fifoQ.push_back(8'h06);
        cycle(1);
        got.delete();
        popTicks.delete();
        runPaced(120, 2);
        checkOutput("stop_pops", popTicks.size(), 2);
        checkOutput("stop_w0", (got.size() > 0) ? got[0] : 8'hxx, 8'h04);
        checkOutput("stop_w1", (got.size() > 1) ? got[1] : 8'hxx, 8'h05);
        checkOutput("stop_left", fifoQ.size(), 1);
        checkOutput("stop_count", rd_count, 3);
        checkOutput("stop_busy", busy, 0);

        $display("[TB] counter wrap");
        rst_n = 1'b0;
        cycle(1);
        fifoQ.delete();
        rst_n = 1'b1;
        cycle(1);
        checkOutput("wrap_reset_count", rd_count, 0);
        for (int i = 0; i < 5; i++) fifoQ.push_back(8'h10 + 8'(i));
        applyStimulus(1'b0, 1'b1, 1'b1);
        cycle(1);
        cntSeq.delete();
        lastCnt = rd_count;
        for (int c = 0; c < 200; c++) begin
            tick = (c % 2 == 0);
            cycle(1);
            if (rd_count !== lastCnt) begin
                cntSeq.push_back(rd_count);
                lastCnt = rd_count;
            end
        end
        tick = 1'b0;
        checkOutput("wrap_len", cntSeq.size(), 5);
        checkOutput("wrap_c0", (cntSeq.size() > 0) ? cntSeq[0] : 2'bxx, 1);
        checkOutput("wrap_c1", (cntSeq.size() > 1) ? cntSeq[1] : 2'bxx, 2);
        checkOutput("wrap_c2", (cntSeq.size() > 2) ? cntSeq[2] : 2'bxx, 3);
        checkOutput("wrap_c3", (cntSeq.size() > 3) ? cntSeq[3] : 2'bxx, 0);
        checkOutput("wrap_c4", (cntSeq.size() > 4) ? cntSeq[4] : 2'bxx, 1);

        $display("[TB] reset while presenting");
        fifoQ.push_back(8'hEE);
        applyStimulus(1'b0, 1'b1, 1'b0);
        cycle(1);
        tick = 1'b1;
        cycle(1);
        tick = 1'b0;
        cycle(2);
        checkOutput("mid_pres_valid", out_valid, 1);
        checkOutput("mid_pres_data", out_data, 8'hEE);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rd_en", fifo_rd_en, 0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_data", out_data, 0);
        checkOutput("mid_rst_count", rd_count, 0);
        checkOutput("mid_rst_busy", busy, 0);
        cycle(2);
        rst_n = 1'b1;
        cycle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
